// File: rtl/gpio_in_pkg.sv
// Shared channel map and event types for the GPIO input conditioner.
// Channels 0-4 are the buttons, 5-12 the switches.
package gpio_in_pkg;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned NUM_SW  = 8;
    localparam int unsigned NUM_CH  = 13;
    localparam int unsigned CHAN_W  = 4;

    localparam int unsigned CH_BTNU = 0;
    localparam int unsigned CH_BTNL = 1;
    localparam int unsigned CH_BTND = 2;
    localparam int unsigned CH_BTNR = 3;
    localparam int unsigned CH_BTNC = 4;
    localparam int unsigned SW_BASE = 5;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              rise;
    } evt_t;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        lowest_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CHAN_W'(i);
        end
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Valid/ready event stream carrying the channel and edge type of each level change.
interface gpio_evt_if;
    import gpio_in_pkg::*;

    logic              valid;
    logic              ready;
    logic [CHAN_W-1:0] chan;
    logic              rise;

    modport master (output valid, output chan, output rise, input ready);
    modport slave  (input valid, input chan, input rise, output ready);

endinterface

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchronizer, debounce counter, stable level and
// registered rise/fall strobes that coincide with the level change.
module debounce_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic                 sync1_q, sync2_q;
    logic                 level_q, rise_q, fall_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Debounces 5 buttons and 8 switches and queues their level changes as events
// through per-channel pending bits feeding a single registered output slot.
module gpio_input_conditioner
    import gpio_in_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_SW-1:0]  sw_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               evt_ovf,
    input  logic               ovf_clr,
    gpio_evt_if.master         evt
);

    logic [NUM_CH-1:0] pins, levels, rises, falls;

    assign pins = {sw, btn};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_debounce_ch (
            .clk  (clk),
            .rst  (rst),
            .pin  (pins[i]),
            .level(levels[i]),
            .rise (rises[i]),
            .fall (falls[i])
        );
    end

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] etype_q, etype_d;
    logic              slot_v_q;
    evt_t              slot_q;
    logic              ovf_q;

    logic              take, load, ovf_set;
    logic [CHAN_W-1:0] pick;

    always_comb begin
        pend_d  = pend_q;
        etype_d = etype_q;
        ovf_set = 1'b0;
        take    = ~slot_v_q | evt.ready;
        load    = take & (|pend_q);
        pick    = lowest_set(pend_q);
        for (int i = 0; i < NUM_CH; i++) begin
            if (rises[i] | falls[i]) begin
                // A newer edge overwrites the recorded one; only an edge that
                // lands on a bit not being drained this cycle counts as lost.
                if (pend_q[i] && !(load && pick == CHAN_W'(i))) ovf_set = 1'b1;
                pend_d[i]  = 1'b1;
                etype_d[i] = rises[i];
            end else if (load && pick == CHAN_W'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            etype_q  <= '0;
            slot_v_q <= 1'b0;
            slot_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            etype_q <= etype_d;
            ovf_q   <= ovf_set | (ovf_q & ~ovf_clr);
            if (take) begin
                slot_v_q <= load;
                slot_q   <= load ? evt_t'{chan: pick, rise: etype_q[pick]} : '0;
            end
        end
    end

    assign btn_level = levels[NUM_BTN-1:0];
    assign sw_level  = levels[NUM_CH-1:SW_BASE];
    assign btn_press = rises[NUM_BTN-1:0];
    assign evt_ovf   = ovf_q;
    assign evt.valid = slot_v_q;
    assign evt.chan  = slot_q.chan;
    assign evt.rise  = slot_q.rise;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Cycle-by-cycle comparison against a behavioural model of debounce and event
// queueing, with directed scenarios followed by randomized pin/handshake traffic.
module tb_gpio_input_conditioner;
    import gpio_in_pkg::*;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [4:0] btn;
    logic [7:0] sw;
    logic [4:0] btn_level, btn_press;
    logic [7:0] sw_level;
    logic       evt_ovf, ovf_clr;

    gpio_evt_if evt ();

    gpio_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .sw       (sw),
        .btn_level(btn_level),
        .sw_level (sw_level),
        .btn_press(btn_press),
        .evt_ovf  (evt_ovf),
        .ovf_clr  (ovf_clr),
        .evt      (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit m_h1[13], m_h2[13], m_lvl[13], m_rise[13], m_fall[13];
    bit m_pend[13], m_et[13];
    int m_run[13];
    bit m_sv, m_srise, m_ovf;
    int m_sch;

    // Handshakes observed on the DUT stream (chan*2 + rise)
    int acc[$];

    task automatic model_reset();
        for (int i = 0; i < 13; i++) begin
            m_h1[i] = 0; m_h2[i] = 0; m_lvl[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
            m_pend[i] = 0; m_et[i] = 0; m_run[i] = 0;
        end
        m_sv = 0; m_srise = 0; m_ovf = 0; m_sch = 0;
    endtask

    task automatic model_update();
        logic [12:0] pins;
        bit take, hit, s;
        bit np[13], ne[13];
        int pick;
        if (rst) begin
            model_reset();
            return;
        end
        // Event side: edges reported last cycle become pending this cycle.
        take = !m_sv || evt.ready;
        pick = -1;
        for (int i = 12; i >= 0; i--) if (m_pend[i]) pick = i;
        hit = 0;
        for (int i = 0; i < 13; i++) begin
            np[i] = m_pend[i];
            ne[i] = m_et[i];
            if (m_rise[i] || m_fall[i]) begin
                if (m_pend[i] && !(take && pick == i)) hit = 1;
                np[i] = 1;
                ne[i] = m_rise[i];
            end else if (take && pick == i) begin
                np[i] = 0;
            end
        end
        if (take) begin
            m_sv = (pick >= 0);
            if (pick >= 0) begin
                m_sch = pick;
                m_srise = m_et[pick];
            end
        end
        m_ovf = hit || (m_ovf && !ovf_clr);
        for (int i = 0; i < 13; i++) begin
            m_pend[i] = np[i];
            m_et[i] = ne[i];
        end
        // Level side: pin seen two edges late, must differ for D edges in a row.
        pins = {sw, btn};
        for (int i = 0; i < 13; i++) begin
            s = m_h2[i];
            m_h2[i] = m_h1[i];
            m_h1[i] = pins[i];
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_lvl[i] = s;
                    m_run[i] = 0;
                    m_rise[i] = s;
                    m_fall[i] = !s;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic compare();
        logic [12:0] lv, pr;
        for (int i = 0; i < 13; i++) begin
            lv[i] = m_lvl[i];
            pr[i] = m_rise[i];
        end
        check("btn_level", 32'(btn_level), 32'(lv[4:0]));
        check("sw_level", 32'(sw_level), 32'(lv[12:5]));
        check("btn_press", 32'(btn_press), 32'(pr[4:0]));
        check("evt_valid", 32'(evt.valid), 32'(m_sv));
        check("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
        if (m_sv) begin
            check("evt_chan", 32'(evt.chan), 32'(m_sch));
            check("evt_rise", 32'(evt.rise), 32'(m_srise));
        end
    endtask

    task automatic step();
        if (evt.valid && evt.ready) acc.push_back(int'(evt.chan) * 2 + int'(evt.rise));
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lvl"}, 32'({btn_level, sw_level, btn_press}), 32'd0);
        check({tag, "_evt"}, 32'({evt.valid, evt.chan, evt.rise, evt_ovf}), 32'd0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; btn = '0; sw = '0; evt.ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) step();

        // Clean button press: level rises exactly D+2 edges after the pin.
        acc.delete();
        evt.ready = 1'b1;
        btn[0] = 1'b1;
        for (int k = 1; k <= D + 2; k++) begin
            step();
            if (k == D + 1) check("press_lvl_early", 32'(btn_level[0]), 32'd0);
        end
        check("press_lvl", 32'(btn_level[0]), 32'd1);
        check("press_pulse", 32'(btn_press[0]), 32'd1);
        step();
        check("press_pulse_end", 32'(btn_press[0]), 32'd0);
        repeat (4) step();
        check("press_evt_cnt", 32'(acc.size()), 32'd1);
        if (acc.size() > 0) check("press_evt", 32'(acc[0]), 32'd1);

        // Glitch shorter than D cycles is filtered.
        acc.delete();
        sw[3] = 1'b1;
        repeat (3) step();
        sw[3] = 1'b0;
        repeat (10) step();
        check("glitch_lvl", 32'(sw_level), 32'd0);
        check("glitch_evt", 32'(acc.size()), 32'd0);
        check("glitch_ovf", 32'(evt_ovf), 32'd0);

        // Two channels qualify together; stalled slot holds the lower channel.
        evt.ready = 1'b0;
        btn[2] = 1'b1; sw[0] = 1'b1;
        repeat (D + 2 + 10) step();
        check("arb_hold_chan", 32'(evt.chan), 32'd2);
        evt.ready = 1'b1;
        step();
        check("arb_next_chan", 32'(evt.chan), 32'd5);
        check("arb_next_valid", 32'(evt.valid), 32'd1);
        step();
        check("arb_empty", 32'(evt.valid), 32'd0);

        // Overflow: two edges on sw[7] while the slot is blocked.
        evt.ready = 1'b0;
        btn[2] = 1'b0;
        repeat (8) step();
        sw[7] = 1'b1;
        repeat (8) step();
        sw[7] = 1'b0;
        repeat (10) step();
        check("ovf_set", 32'(evt_ovf), 32'd1);
        evt.ready = 1'b1;
        step();
        check("ovf_evt_chan", 32'(evt.chan), 32'd12);
        check("ovf_evt_rise", 32'(evt.rise), 32'd0);
        evt.ready = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(evt_ovf), 32'd0);
        evt.ready = 1'b1;
        repeat (3) step();

        // Reset mid-debounce with a full slot discards everything.
        evt.ready = 1'b0;
        btn[1] = 1'b1;
        repeat (8) step();
        btn[4] = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        for (int k = 1; k <= D + 2; k++) begin
            step();
            if (k == D + 1) check("midrst_lvl_early", 32'(btn_level[4]), 32'd0);
        end
        check("midrst_lvl", 32'(btn_level[4]), 32'd1);
        evt.ready = 1'b1;
        repeat (12) step();

        // Switches held high through reset rise in ascending channel order.
        rst = 1'b1; btn = '0; sw = 8'hFF;
        step(); step();
        rst = 1'b0;
        acc.delete();
        repeat (20) step();
        check("sw_reset_cnt", 32'(acc.size()), 32'd8);
        for (int k = 0; k < 8 && k < acc.size(); k++)
            check("sw_reset_evt", 32'(acc[k]), 32'((SW_BASE + k) * 2 + 1));

        // Randomized traffic with stalls, overflow clears and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++) if ($urandom_range(39) == 0) btn[i] = ~btn[i];
            for (int i = 0; i < 8; i++) if ($urandom_range(39) == 0) sw[i] = ~sw[i];
            evt.ready = ($urandom_range(9) < 7);
            ovf_clr = ($urandom_range(49) == 0);
            rst = ($urandom_range(499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive cycles a synchronized input must differ from its stable level before the stable level changes; legal range 2..2^24-1.
REQ-002 Parameter CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES+1), debounce counter width.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 btn  input  5  raw asynchronous buttons, bit order {btnc,btnr,btnd,btnl,btnu}, btnu at bit 0.
REQ-006 sw  input  8  raw asynchronous switches.
REQ-007 btn_level  output  5  debounced button levels.
REQ-008 sw_level  output  8  debounced switch levels.
REQ-009 btn_press  output  5  one-cycle pulse per debounced 0->1 button transition.
REQ-010 evt_valid  output  1  event available.
REQ-011 evt_ready  input  1  consumer accepts the event.
REQ-012 evt_chan  output  4  channel of the event: 0-4 = btn[0..4], 5-12 = sw[0..7].
REQ-013 evt_rise  output  1  1 = 0->1 transition, 0 = 1->0 transition.
REQ-014 evt_ovf  output  1  sticky overflow flag.
REQ-015 ovf_clr  input  1  clears evt_ovf.

Function
REQ-016 Each of the 13 channels shall pass through a 2-flop synchronizer before any other logic.
REQ-017 Per channel: counter increments while sync != stable, resets to 0 in any cycle sync == stable; when the counter reaches DEBOUNCE_CYCLES-1 with sync != stable, stable takes the sync value and the counter clears.
REQ-018 Latency from a clean pin change to the level output change shall be exactly DEBOUNCE_CYCLES+2 clock edges; glitches shorter than DEBOUNCE_CYCLES cycles shall produce no level change.
REQ-019 btn_press[i] shall assert in the same cycle btn_level[i] rises, for exactly one cycle.
REQ-020 Every stable-level change sets the channel's pending bit and records its edge type (rise/fall).
REQ-021 If a channel's pending bit is already set when a new edge occurs, the recorded edge type is overwritten with the newer one, the bit stays set, and evt_ovf is set.
REQ-022 The event output is a registered slot: when the slot is empty, or when evt_valid && evt_ready, the lowest-index pending channel loads into the slot and its pending bit clears in that cycle.
REQ-023 An edge on the channel being loaded in that same cycle leaves the pending bit set with the new edge type; no overflow is flagged.
REQ-024 evt_chan and evt_rise shall remain stable while evt_valid && !evt_ready.
REQ-025 Back-to-back acceptance shall sustain one event per cycle while pending bits remain.
REQ-026 ovf_clr clears evt_ovf; a same-cycle overflow condition wins (evt_ovf stays 1).

Reset
REQ-027 rst clears all synchronizer flops, stable levels, counters, pending bits, edge-type bits, the event slot, and evt_ovf; all outputs read 0 in the cycle after rst is sampled high.
REQ-028 Inputs held high across reset shall produce a normal rise event after DEBOUNCE_CYCLES+2 cycles from reset release.
REQ-029 rst asserted mid-debounce or with a pending or unaccepted event discards all state; no event is emitted after release unless newly qualified.

Structure
REQ-030 A shared package gpio_in_pkg shall hold NUM_BTN=5, NUM_SW=8, NUM_CH=13, CHAN_W=4, and the channel-index constants for each button and SW_BASE=5.
REQ-031 One sub-module, debounce_ch (synchronizer + counter + stable level + edge strobes), shall be instantiated 13 times; the pending/arbitration/slot logic resides in the top of this block.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 btn[0] 0->1 held steady -> btn_level[0] rises exactly 6 edges later, btn_press[0] one cycle, event chan=0 rise=1.
REQ-033 sw[3] pulses high for 3 cycles -> no level change, no event, evt_ovf=0.
REQ-034 btn[2] and sw[0] qualify the same cycle, evt_ready=0 for 10 cycles then 1 -> chan=2 held stable, then chan=5 next cycle, then evt_valid=0.
REQ-035 sw[7] rises then falls (each held 8 cycles) with evt_ready=0 and the slot already full -> single pending event chan=12 rise=0, evt_ovf=1; ovf_clr -> evt_ovf=0.
REQ-036 rst pulse while btn[4] counter at 2 and an event in the slot -> outputs 0, no event for btn[4] unless it requalifies for a full 4+2 cycles.
REQ-037 All sw high through reset -> 8 rise events, chan 5..12 in ascending order, with evt_ready held at 1.
